// File: rtl/seq_pkg.sv
// Shared constants for the pattern transmitter and the sequence-detector benches.
package seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam int         PAT_W_DEF = 5;
  localparam logic [4:0] PAT_10110 = 5'b10110;
endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; load has priority over decrement.
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter, MSB first, with repeat count and idle gap.
// Build option SEQ_TX_PARITY_EN appends an even-parity bit after each pattern.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int             PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PAT_10110),
  parameter int             REP_W   = 4,
  parameter int             GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(PAT_W);

  seq_state_e       state_q, state_d;
  logic             out_q, out_d;
  logic [GAP_W-1:0] gap_q;

  logic [BW-1:0]    bit_idx, idx_m1;
  logic             bit_zero, bit_load, bit_dec;
  logic [REP_W-1:0] reps_left, reps_init;
  logic             reps_zero, reps_load, reps_dec;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_zero, gap_load, gap_dec;
  logic             end_pat;

  assign idx_m1    = bit_idx - BW'(1);
  assign reps_init = (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
  assign reps_load = (state_q == IDLE) && start;

  seq_down_counter #(.W(BW)) u_bit (
    .clk(clk), .rst_n(rst_n), .load(bit_load), .load_val(BW'(PAT_W-1)),
    .dec(bit_dec), .cnt(bit_idx), .zero(bit_zero)
  );

  seq_down_counter #(.W(REP_W)) u_reps (
    .clk(clk), .rst_n(rst_n), .load(reps_load), .load_val(reps_init),
    .dec(reps_dec), .cnt(reps_left), .zero(reps_zero)
  );

  // Gap counter is loaded with gap-1 so the zero flag marks the last idle cycle.
  seq_down_counter #(.W(GAP_W)) u_gap (
    .clk(clk), .rst_n(rst_n), .load(gap_load), .load_val(gap_q - GAP_W'(1)),
    .dec(gap_dec), .cnt(gap_cnt), .zero(gap_zero)
  );

  logic unused;
  assign unused = ^{reps_zero, gap_cnt};

`ifdef SEQ_TX_PARITY_EN
  localparam logic PAR_BIT = ^PATTERN;
  logic par_q, par_d;
  assign end_pat = bit_zero && par_q;
`else
  assign end_pat = bit_zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
      gap_q   <= '0;
`ifdef SEQ_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (reps_load) gap_q <= gap;
`ifdef SEQ_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // out_d is the bit that will be on the line in the cycle state_d names.
  always_comb begin
    state_d  = state_q;
    out_d    = 1'b0;
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    reps_dec = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    par_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SEND;
          bit_load = 1'b1;
          out_d    = PATTERN[PAT_W-1];
        end
      end
      SEND: begin
        if (end_pat) begin
          if (reps_left != REP_W'(1)) begin
            reps_dec = 1'b1;
            if (gap_q != '0) begin
              state_d  = GAP;
              gap_load = 1'b1;
            end else begin
              bit_load = 1'b1;
              out_d    = PATTERN[PAT_W-1];
            end
          end else begin
            state_d = DONE;
          end
`ifdef SEQ_TX_PARITY_EN
        end else if (bit_zero) begin
          par_d = 1'b1;
          out_d = PAR_BIT;
`endif
        end else begin
          bit_dec = 1'b1;
          out_d   = PATTERN[idx_m1];
        end
      end
      GAP: begin
        if (gap_zero) begin
          state_d  = SEND;
          bit_load = 1'b1;
          out_d    = PATTERN[PAT_W-1];
        end else begin
          gap_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out   = out_q;
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      SEND:    begin valid = 1'b1; busy = 1'b1; end
      GAP:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx against a cycle-list reference model.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int             PW  = PAT_W_DEF;
  localparam logic [PW-1:0]  PAT = PAT_10110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] rep_cnt = '0;
  logic [3:0] gap = '0;
  logic       out, valid, busy, done;

  int errs = 0;
  int checks = 0;

  logic [3:0] exp_q[$];   // {out, valid, busy, done} per cycle

  always #5 clk = ~clk;

  seq_pattern_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rep_cnt(rep_cnt), .gap(gap),
    .out(out), .valid(valid), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One frame as a list of cycles: bits, optional parity, gaps, then done.
  function automatic void add_frame(input int r, input int g);
    int reps;
    reps = (r == 0) ? 1 : r;
    for (int k = 0; k < reps; k++) begin
      for (int b = PW - 1; b >= 0; b--) exp_q.push_back({PAT[b], 3'b110});
`ifdef SEQ_TX_PARITY_EN
      exp_q.push_back({^PAT, 3'b110});
`endif
      if (k < reps - 1)
        for (int j = 0; j < g; j++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endfunction

  task automatic run_frame(input int r, input int g, input bit noisy, input bit hold,
                           output int det);
    int n;
    logic [PW-1:0] win;
    exp_q = {};
    add_frame(r, g);
    n = exp_q.size();
    exp_q.push_back(4'b0000);
    if (hold) begin
      add_frame(r, g);
      exp_q.push_back(4'b0000);
    end
    @(negedge clk);
    start = 1'b1; rep_cnt = 4'(r); gap = 4'(g);
    win = '0; det = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("r%0d_g%0d_c%0d", r, g, i), {out, valid, busy, done}, exp_q[i]);
      if (valid) begin
        win = {win[PW-2:0], out};
        if (win == PAT) det++;
      end
      if (hold) start = (i <= n);
      else if (noisy && i < n) begin
        start   = 1'($urandom_range(0, 1));
        rep_cnt = 4'($urandom_range(0, 15));
        gap     = 4'($urandom_range(0, 15));
      end else start = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    int det;
    #3;
    chk("reset_async", {out, valid, busy, done}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {out, valid, busy, done}, 4'b0000);

    run_frame(1, 0, 1'b0, 1'b0, det);
    run_frame(3, 0, 1'b0, 1'b0, det);
`ifndef SEQ_TX_PARITY_EN
    chk("detect_x3", det, 3);
`endif
    run_frame(2, 2, 1'b0, 1'b0, det);
    run_frame(0, 3, 1'b0, 1'b0, det);
    run_frame(1, 0, 1'b0, 1'b1, det);
    run_frame(2, 1, 1'b1, 1'b0, det);
    run_frame(15, 15, 1'b0, 1'b0, det);

    for (int t = 0; t < 30; t++)
      run_frame($urandom_range(0, 15), $urandom_range(0, 15), 1'b1, 1'b0, det);

    // Reset dropped in the middle of a pattern must clear outputs without a clock.
    @(negedge clk);
    start = 1'b1; rep_cnt = 4'd2; gap = 4'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_send", {valid, busy, done}, 3'b110);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_send", {out, valid, busy, done}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("idle_post_reset_%0d", i), {out, valid, busy, done}, 4'b0000);
    end
    run_frame(1, 0, 1'b0, 1'b0, det);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
